// File: rtl/dm_lane_pkg.sv
// ---------------------------------------------------------------------------
// dm_lane_pkg
// Shared definitions for the M-stage data-memory path: load-extension op
// codes and the timer device windows. The byte-enable generator and the
// data-memory responder both import this so the window bounds and op
// encodings live in exactly one place.
// ---------------------------------------------------------------------------
package dm_lane_pkg;

    // Default geometry: 4096 words of 32 bits, 12-bit word index.
    localparam int DM_DEPTH = 4096;
    localparam int DM_AW    = 12;

    // Load-extension operations carried on DEOp.
    typedef enum logic [2:0] {
        de_lw  = 3'd0,
        de_lbu = 3'd1,
        de_lb  = 3'd2,
        de_lhu = 3'd3,
        de_lh  = 3'd4
    } de_op_e;

    // Timer register windows (inclusive, unsigned byte addresses).
    localparam logic [31:0] TIMER0_LO = 32'h0000_7f00;
    localparam logic [31:0] TIMER0_HI = 32'h0000_7f0b;
    localparam logic [31:0] TIMER1_LO = 32'h0000_7f10;
    localparam logic [31:0] TIMER1_HI = 32'h0000_7f1b;

    // True when the byte address falls inside either timer window.
    function automatic logic in_timer_window(input logic [31:0] addr);
        return ((addr >= TIMER0_LO) && (addr <= TIMER0_HI)) ||
               ((addr >= TIMER1_LO) && (addr <= TIMER1_HI));
    endfunction

endpackage

// File: rtl/dm_lane_dext.sv
// ---------------------------------------------------------------------------
// dm_lane_dext
// Purely combinational load extractor. Picks the addressed byte / halfword /
// word out of the fetched memory word, zero- or sign-extends it, and flags
// load address errors (misalignment or sub-word access to a timer window).
//
// Ports:
//   word_i  [31:0]  raw memory word (already 0 when out of range)
//   addr_i  [31:0]  full byte address (low bits select lane, all bits for
//                   the timer-window check)
//   deop_i  [2:0]   load-extension op (de_op_e encoding)
//   rd_o    [31:0]  extended load data
//   adel_o          load address error
// ---------------------------------------------------------------------------
module dm_lane_dext
    import dm_lane_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] addr_i,
    input  logic [2:0]  deop_i,
    output logic [31:0] rd_o,
    output logic        adel_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        timer_hit;

    assign timer_hit = in_timer_window(addr_i);

    always_comb begin
        byte_sel = 8'h00;
        case (addr_i[1:0])
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
    end

    // Halfword selection uses Addr[1] only; a misaligned lh still extracts
    // (the error flag tells the pipeline to drop it).
    assign half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];

    always_comb begin
        rd_o   = word_i;
        adel_o = 1'b0;
        case (deop_i)
            de_lw: begin
                rd_o   = word_i;
                adel_o = (addr_i[1:0] != 2'b00);
            end
            de_lbu: begin
                rd_o   = {24'h000000, byte_sel};
                adel_o = timer_hit;
            end
            de_lb: begin
                rd_o   = {{24{byte_sel[7]}}, byte_sel};
                adel_o = timer_hit;
            end
            de_lhu: begin
                rd_o   = {16'h0000, half_sel};
                adel_o = addr_i[0] | timer_hit;
            end
            de_lh: begin
                rd_o   = {{16{half_sel[15]}}, half_sel};
                adel_o = addr_i[0] | timer_hit;
            end
            default: begin
                rd_o   = word_i;
                adel_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dm_lane.sv
// ---------------------------------------------------------------------------
// dm_lane
// Data-memory responder for the M stage. Holds DEPTH 32-bit words split into
// four byte-lane arrays, commits stores lane-by-lane on the rising clock
// edge, and returns the extended load result combinationally.
//
// Ports:
//   clk            system clock, writes on rising edge
//   reset          asynchronous active-high; clears every word at once
//   WE             store request
//   Flush          exception in M this cycle; suppresses the store
//   Addr   [31:0]  byte address
//   Be     [3:0]   byte-lane enables (lanes already positioned)
//   WD     [31:0]  store data (already lane-aligned, not shifted here)
//   DEOp   [2:0]   load-extension op
//   RD     [31:0]  extended load data (0-latency)
//   adel           load address error
// ---------------------------------------------------------------------------
module dm_lane
    import dm_lane_pkg::*;
#(
    parameter int DEPTH = DM_DEPTH,
    parameter int AW    = DM_AW
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic        Flush,
    input  logic [31:0] Addr,
    input  logic [3:0]  Be,
    input  logic [31:0] WD,
    input  logic [2:0]  DEOp,
    output logic [31:0] RD,
    output logic        adel
);

    logic [AW-1:0] word_idx;
    logic          in_range;
    logic          wr_en;
    logic [31:0]   word_rd;

    assign word_idx = Addr[AW+1:2];

    // Full 32-bit compare: addresses past the array never alias onto it.
    assign in_range = (Addr < 32'(DEPTH * 4));

    // adel is deliberately not part of the write qualifier; store address
    // errors are resolved upstream by forcing WE low or Flush high.
    assign wr_en = WE && !Flush && in_range;

    // One array per byte lane so each Be bit gates only its own storage.
    // The asynchronous clear is why these are flops rather than block RAM.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_q [DEPTH];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        lane_q[i] <= 8'h00;
                    end
                end else if (wr_en && Be[gi]) begin
                    lane_q[word_idx] <= WD[8*gi +: 8];
                end
            end

            // No write bypass: a same-address read shows the old byte until
            // the edge commits the new one.
            assign word_rd[8*gi +: 8] = in_range ? lane_q[word_idx] : 8'h00;
        end
    endgenerate

    dm_lane_dext u_dext (
        .word_i (word_rd),
        .addr_i (Addr),
        .deop_i (DEOp),
        .rd_o   (RD),
        .adel_o (adel)
    );

endmodule

// File: tb/tb_dm_lane.sv
// ---------------------------------------------------------------------------
// tb_dm_lane
// Scoreboard bench for dm_lane: every load pushes its expected RD/adel onto a
// queue when it is driven, and the entry is popped and compared once the
// combinational result has settled. A byte-addressed reference memory tracks
// committed stores for the randomized section.
// ---------------------------------------------------------------------------
module tb_dm_lane;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LBU = 3'd1;
    localparam logic [2:0] OP_LB  = 3'd2;
    localparam logic [2:0] OP_LHU = 3'd3;
    localparam logic [2:0] OP_LH  = 3'd4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        WE = 1'b0;
    logic        Flush = 1'b0;
    logic [31:0] Addr = 32'h0;
    logic [3:0]  Be = 4'h0;
    logic [31:0] WD = 32'h0;
    logic [2:0]  DEOp = 3'd0;
    logic [31:0] RD;
    logic        adel;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] rd;
        logic        adel;
    } exp_t;

    exp_t sb_q[$];

    logic [7:0] ref_mem [int];

    dm_lane dut (
        .clk   (clk),
        .reset (reset),
        .WE    (WE),
        .Flush (Flush),
        .Addr  (Addr),
        .Be    (Be),
        .WD    (WD),
        .DEOp  (DEOp),
        .RD    (RD),
        .adel  (adel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Pop the oldest expectation and compare against what the DUT shows now.
    task automatic sb_compare();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            $display("load %-14s addr=%08h op=%0d rd=%08h adel=%0b", e.tag, Addr, DEOp, RD, adel);
            check({e.tag, ".rd"}, RD, e.rd);
            check({e.tag, ".adel"}, {31'b0, adel}, {31'b0, e.adel});
        end
    endtask

    task automatic expect_now(input string tag, input logic [31:0] erd, input logic eadel);
        sb_q.push_back('{tag, erd, eadel});
        #1;
        sb_compare();
    endtask

    task automatic load(input string tag, input logic [31:0] a, input logic [2:0] op,
                        input logic [31:0] erd, input logic eadel);
        @(negedge clk);
        WE   = 1'b0;
        Addr = a;
        DEOp = op;
        sb_q.push_back('{tag, erd, eadel});
        #1;
        sb_compare();
    endtask

    task automatic store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                         input logic fl);
        @(negedge clk);
        Addr  = a;
        Be    = be;
        WD    = wd;
        WE    = 1'b1;
        Flush = fl;
        @(posedge clk);
        #1;
        $display("store addr=%08h be=%04b wd=%08h flush=%0b", a, be, wd, fl);
        if (!fl && a < 32'h4000 && !reset) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) ref_mem[int'({a[31:2], 2'b00}) + k] = wd[8*k +: 8];
            end
        end
        WE    = 1'b0;
        Flush = 1'b0;
    endtask

    function automatic logic [7:0] mb(input logic [31:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a, input logic [2:0] op);
        logic [31:0] w;
        logic [31:0] h;
        logic [7:0]  b;
        logic [15:0] hv;
        w  = {a[31:2], 2'b00};
        h  = w + {30'b0, a[1], 1'b0};
        b  = mb(a);
        hv = {mb(h + 1), mb(h)};
        case (op)
            OP_LBU:  return {24'h0, b};
            OP_LB:   return {{24{b[7]}}, b};
            OP_LHU:  return {16'h0, hv};
            OP_LH:   return {{16{hv[15]}}, hv};
            default: return {mb(w + 3), mb(w + 2), mb(w + 1), mb(w)};
        endcase
    endfunction

    function automatic logic model_adel(input logic [31:0] a, input logic [2:0] op);
        logic tw;
        tw = (a >= 32'h7f00 && a <= 32'h7f0b) || (a >= 32'h7f10 && a <= 32'h7f1b);
        case (op)
            OP_LW:          return a[1:0] != 2'b00;
            OP_LH, OP_LHU:  return a[0] | tw;
            OP_LB, OP_LBU:  return tw;
            default:        return 1'b0;
        endcase
    endfunction

    initial begin
        // Power-up async reset, read while held.
        #2 reset = 1'b1;
        expect_now("rst_hold_0", 32'h0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Populate two words, then clear them asynchronously mid-cycle.
        store(32'h0000_0000, 4'hf, 32'hCAFE_F00D, 1'b0);
        store(32'h0000_3ffc, 4'hf, 32'h0123_4567, 1'b0);
        load("pre_0", 32'h0, OP_LW, 32'hCAFE_F00D, 1'b0);
        load("pre_3ffc", 32'h3ffc, OP_LW, 32'h0123_4567, 1'b0);
        @(posedge clk);
        #3 reset = 1'b1;
        ref_mem.delete();
        expect_now("arst_3ffc", 32'h0, 1'b0);
        Addr = 32'h0;
        expect_now("arst_0", 32'h0, 1'b0);

        // Reset held across a write edge: reset wins.
        @(negedge clk);
        Addr = 32'h0; Be = 4'hf; WD = 32'hFFFF_FFFF; WE = 1'b1;
        @(posedge clk);
        #1 WE = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        load("rst_mid_wr", 32'h0, OP_LW, 32'h0, 1'b0);

        // Word write and byte-lane merge.
        store(32'h10, 4'hf, 32'hDEAD_BEEF, 1'b0);
        load("lw_10", 32'h10, OP_LW, 32'hDEAD_BEEF, 1'b0);
        store(32'h12, 4'b0100, 32'h00AA_0000, 1'b0);
        load("lw_merge", 32'h10, OP_LW, 32'hDEAA_BEEF, 1'b0);
        load("lb_12", 32'h12, OP_LB, 32'hFFFF_FFAA, 1'b0);
        load("lbu_12", 32'h12, OP_LBU, 32'h0000_00AA, 1'b0);
        load("lh_12", 32'h12, OP_LH, 32'hFFFF_DEAA, 1'b0);
        load("lhu_10", 32'h10, OP_LHU, 32'h0000_BEEF, 1'b0);
        load("lb_13", 32'h13, OP_LB, 32'hFFFF_FFDE, 1'b0);
        load("lbu_11", 32'h11, OP_LBU, 32'h0000_00BE, 1'b0);

        // Suppressed writes.
        store(32'h10, 4'hf, 32'h1234_5678, 1'b1);
        load("flush", 32'h10, OP_LW, 32'hDEAA_BEEF, 1'b0);
        store(32'h10, 4'h0, 32'h1234_5678, 1'b0);
        load("be_zero", 32'h10, OP_LW, 32'hDEAA_BEEF, 1'b0);
        store(32'h0, 4'hf, 32'h0BAD_F00D, 1'b0);
        store(32'h4000, 4'hf, 32'h5555_5555, 1'b0);
        load("no_wrap_0", 32'h0, OP_LW, 32'h0BAD_F00D, 1'b0);
        load("oor_4000", 32'h4000, OP_LW, 32'h0, 1'b0);

        // Address errors and window edges.
        load("lw_2", 32'h2, OP_LW, 32'h0BAD_F00D, 1'b1);
        load("lh_11", 32'h11, OP_LH, 32'hFFFF_BEEF, 1'b1);
        load("lhu_12", 32'h12, OP_LHU, 32'h0000_DEAA, 1'b0);
        load("lb_7f04", 32'h7f04, OP_LB, 32'h0, 1'b1);
        load("lb_7f0c", 32'h7f0c, OP_LB, 32'h0, 1'b0);
        load("lh_7f1a", 32'h7f1a, OP_LH, 32'h0, 1'b1);
        load("lw_7f00", 32'h7f00, OP_LW, 32'h0, 1'b0);
        load("lbu_7f0b", 32'h7f0b, OP_LBU, 32'h0, 1'b1);
        load("lbu_7eff", 32'h7eff, OP_LBU, 32'h0, 1'b0);
        load("lhu_7f10", 32'h7f10, OP_LHU, 32'h0, 1'b1);
        load("lb_7f1c", 32'h7f1c, OP_LB, 32'h0, 1'b0);
        load("undef_op", 32'h11, 3'd7, 32'hDEAA_BEEF, 1'b0);

        // Same-address read during write: old data before the edge.
        @(negedge clk);
        Addr = 32'h20; DEOp = OP_LW; Be = 4'hf; WD = 32'h1111_1111; WE = 1'b1;
        expect_now("rdw_before", 32'h0, 1'b0);
        @(posedge clk);
        #1 WE = 1'b0;
        for (int k = 0; k < 4; k++) ref_mem[32'h20 + k] = 8'h11;
        expect_now("rdw_after", 32'h1111_1111, 1'b0);

        // Randomized stores/loads against the byte-addressed model.
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            logic [2:0]  op;
            a  = 32'h100 + 32'($urandom_range(0, 63));
            op = 3'($urandom_range(0, 4));
            if ($urandom_range(0, 1) == 0) begin
                store(a, 4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 7) == 0);
            end else begin
                load("rand", a, op, model_rd(a, op), model_adel(a, op));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
